// File: rtl/sampling_pkg.sv
// Shared types and constants for the sampling lane controller.
// Element format is signed Q4.11.
package sampling_pkg;

  localparam int BITSIZE      = 16;
  localparam int Q_INT        = 4;
  localparam int Q_FRAC       = 11;
  localparam int LANE_LAT_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sampling_track_sr.sv
// Depth-LANE_LAT shift register of {valid, index} that shadows the lane.
// Synchronous clear drops every in-flight element.
module sampling_track_sr #(
  parameter int DEPTH = 5,
  parameter int IW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_v,
  input  logic [IW-1:0] push_idx,
  output logic          tail_v,
  output logic [IW-1:0] tail_idx
);

  logic [DEPTH-1:0] v_q;
  logic [IW-1:0]    idx_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      v_q[0]   <= push_v;
      idx_q[0] <= push_idx;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i]   <= v_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign tail_v   = v_q[DEPTH-1];
  assign tail_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/sampling_sched.sv
// Issues one latent element per cycle into the sampling lane and reassembles results.
// Optional epsilon tap: define SAMPLING_SCHED_EPS_TAP_EN.
module sampling_sched
  import sampling_pkg::*;
#(
  parameter int N_LATENT = 8,
  parameter int BITSIZE  = sampling_pkg::BITSIZE,
  parameter int LANE_LAT = LANE_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_LATENT*BITSIZE-1:0]  in_ac,
  input  logic [N_LATENT*BITSIZE-1:0]  in_ad,
  output logic [BITSIZE-1:0]           lane_ac,
  output logic [BITSIZE-1:0]           lane_ad,
  input  logic [BITSIZE-1:0]           lane_a,
`ifdef SAMPLING_SCHED_EPS_TAP_EN
  input  logic [BITSIZE-1:0]           lane_eps,
  output logic [N_LATENT*BITSIZE-1:0]  out_eps,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_LATENT*BITSIZE-1:0]  out_a,
  output logic [15:0]                  sample_cnt,
  output logic                         busy
);

  localparam int IW = idx_w(N_LATENT);
  localparam int VW = N_LATENT * BITSIZE;
  localparam logic [IW-1:0] LAST = IW'(N_LATENT - 1);

  state_t        state_q, state_d;
  logic [VW-1:0] ac_q, ad_q;
  logic [IW-1:0] idx_q;
  logic [15:0]   cnt_q;
  logic          push_v;
  logic          tail_v;
  logic [IW-1:0] tail_idx;
  logic          accept, retire, issue;

  assign accept = (state_q == IDLE) && in_valid;
  assign retire = (state_q == DONE) && out_ready;
  assign issue  = (state_q == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ac_q    <= '0;
      ad_q    <= '0;
      idx_q   <= '0;
      out_a   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ac_q  <= in_ac;
        ad_q  <= in_ad;
        idx_q <= '0;
      end else if (issue) begin
        idx_q <= idx_q + IW'(1);
      end
      // Lane has no valid; the tracker decides what lands where
      if (tail_v)
        out_a[int'(tail_idx)*BITSIZE +: BITSIZE] <= lane_a;
      if (retire)
        cnt_q <= cnt_q + 16'd1;
    end
  end

`ifdef SAMPLING_SCHED_EPS_TAP_EN
  always_ff @(posedge clk) begin
    if (rst)
      out_eps <= '0;
    else if (tail_v)
      out_eps[int'(tail_idx)*BITSIZE +: BITSIZE] <= lane_eps;
  end
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    push_v    = 1'b0;
    lane_ac   = '0;
    lane_ad   = '0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ISSUE;
      end
      ISSUE: begin
        push_v  = 1'b1;
        lane_ac = ac_q[int'(idx_q)*BITSIZE +: BITSIZE];
        lane_ad = ad_q[int'(idx_q)*BITSIZE +: BITSIZE];
        if (idx_q == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (tail_v && tail_idx == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sampling_track_sr #(
    .DEPTH (LANE_LAT),
    .IW    (IW)
  ) u_track (
    .clk      (clk),
    .rst      (rst),
    .push_v   (push_v),
    .push_idx (idx_q),
    .tail_v   (tail_v),
    .tail_idx (tail_idx)
  );

  assign sample_cnt = cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sampling_sched.sv
// Bench for sampling_sched: N=2/LAT=5 and N=1/LAT=1 instances with lane stubs.
// Expected vectors are element-wise ac+ad sums; latencies follow accept timing.
module tb_sampling_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // ---------------- instance A: N_LATENT=2, LANE_LAT=5
  logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic        a_in_ready, a_out_valid, a_busy;
  logic [31:0] a_in_ac = '0, a_in_ad = '0, a_out_a;
  logic [15:0] a_lane_ac, a_lane_ad, a_lane_a, a_cnt;
  logic [15:0] a_pipe [5];

  always @(posedge clk) begin
    a_pipe[0] <= a_lane_ac + a_lane_ad;
    for (int i = 1; i < 5; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign a_lane_a = a_pipe[4];

`ifdef SAMPLING_SCHED_EPS_TAP_EN
  logic [15:0] a_lane_eps, a_k;
  logic [31:0] a_out_eps;
  logic [15:0] a_epipe [5];
  always @(posedge clk) begin
    if (a_in_valid && a_in_ready) a_k <= '0;
    else a_k <= a_k + 16'd1;
    a_epipe[0] <= 16'h0800 + a_k;
    for (int i = 1; i < 5; i++) a_epipe[i] <= a_epipe[i-1];
  end
  assign a_lane_eps = a_epipe[4];
`endif

  sampling_sched #(.N_LATENT(2), .BITSIZE(16), .LANE_LAT(5)) u_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_ac      (a_in_ac),
    .in_ad      (a_in_ad),
    .lane_ac    (a_lane_ac),
    .lane_ad    (a_lane_ad),
    .lane_a     (a_lane_a),
`ifdef SAMPLING_SCHED_EPS_TAP_EN
    .lane_eps   (a_lane_eps),
    .out_eps    (a_out_eps),
`endif
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_a      (a_out_a),
    .sample_cnt (a_cnt),
    .busy       (a_busy)
  );

  // ---------------- instance B: N_LATENT=1, LANE_LAT=1, out_ready tied high
  logic        b_in_valid = 1'b0;
  logic        b_out_ready = 1'b1;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [15:0] b_in_ac = '0, b_in_ad = '0, b_out_a;
  logic [15:0] b_lane_ac, b_lane_ad, b_lane_a, b_cnt;
  logic [15:0] b_pipe;

  always @(posedge clk) b_pipe <= b_lane_ac + b_lane_ad;
  assign b_lane_a = b_pipe;

`ifdef SAMPLING_SCHED_EPS_TAP_EN
  logic [15:0] b_out_eps;
`endif

  sampling_sched #(.N_LATENT(1), .BITSIZE(16), .LANE_LAT(1)) u_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_ac      (b_in_ac),
    .in_ad      (b_in_ad),
    .lane_ac    (b_lane_ac),
    .lane_ad    (b_lane_ad),
    .lane_a     (b_lane_a),
`ifdef SAMPLING_SCHED_EPS_TAP_EN
    .lane_eps   (16'h0800),
    .out_eps    (b_out_eps),
`endif
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_a      (b_out_a),
    .sample_cnt (b_cnt),
    .busy       (b_busy)
  );

  // ---------------- reference model: each element is ac+ad, modulo 2^16
  function automatic logic [31:0] model2(input logic [31:0] ac, input logic [31:0] ad);
    logic [31:0] r;
    for (int k = 0; k < 2; k++) r[k*16 +: 16] = ac[k*16 +: 16] + ad[k*16 +: 16];
    return r;
  endfunction

  task automatic a_send(input logic [31:0] ac, input logic [31:0] ad);
    int n;
    n = 0;
    a_in_ac = ac;
    a_in_ad = ad;
    a_in_valid = 1'b1;
    while (!a_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("a_accept_ready", a_in_ready, 1);
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  // Cycle 1 is the one following the accept edge
  task automatic a_wait(output int lat);
    lat = 1;
    while (!a_out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic a_retire();
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ac;
    logic [31:0] ad;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int lat;
    int cnt_m;
    int hold;
    int last_acc;
    int b_done;
    logic [31:0] ac, ad, e;
    int b_acc_q [$];
    logic [15:0] b_exp_q [$];

    tbl[0] = '{32'h0800_1000, 32'h0100_0200, 32'h0900_1200};
    tbl[1] = '{32'hFFFF_0001, 32'h0001_0001, 32'h0000_0002};
    tbl[2] = '{32'h8000_7000, 32'h0001_0FFF, 32'h8001_7FFF};
    tbl[3] = '{32'h4321_1234, 32'h2222_1111, 32'h6543_2345};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_out_a", a_out_a, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_lane", {a_lane_ac, a_lane_ad}, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_out_a", b_out_a, 0);
`ifdef SAMPLING_SCHED_EPS_TAP_EN
    chk("rst_a_out_eps", a_out_eps, 0);
`endif

    // table vectors
    for (int i = 0; i < 4; i++) begin
      a_send(tbl[i].ac, tbl[i].ad);
      chk("tbl_lane_ac0", a_lane_ac, {48'd0, tbl[i].ac[15:0]});
      a_wait(lat);
      chk("tbl_latency", lat, 8);
      chk("tbl_out_a", a_out_a, tbl[i].exp);
`ifdef SAMPLING_SCHED_EPS_TAP_EN
      chk("tbl_out_eps", a_out_eps, 32'h0801_0800);
`endif
      a_retire();
      chk("tbl_cnt", a_cnt, i + 1);
      chk("tbl_idle", a_in_ready, 1);
    end

    // output back-pressure with a pending input vector
    a_send(tbl[3].ac, tbl[3].ad);
    a_wait(lat);
    a_in_ac = 32'h1111_1111;
    a_in_ad = 32'h0;
    a_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_out_a", a_out_a, tbl[3].exp);
      chk("bp_in_ready", a_in_ready, 0);
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    chk("bp_no_same_cycle_accept", a_busy, 0);
    chk("bp_idle_ready", a_in_ready, 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("bp_accept_after", a_busy, 1);
    a_wait(lat);
    chk("bp2_latency", lat, 8);
    chk("bp2_out_a", a_out_a, 32'h1111_1111);
    a_retire();
    chk("bp_cnt", a_cnt, 6);

    // reset while element 1 is being issued
    a_send(tbl[0].ac, tbl[0].ad);
    @(negedge clk);
    chk("rs_lane_ac1", a_lane_ac, 16'h0800);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_in_ready", a_in_ready, 1);
    chk("rs_out_valid", a_out_valid, 0);
    chk("rs_busy", a_busy, 0);
    chk("rs_cnt", a_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      chk("rs_no_stale", a_out_a, 0);
      @(negedge clk);
    end
    a_send(32'h0, 32'h0);
    a_wait(lat);
    chk("rs_latency", lat, 8);
    chk("rs_out_a", a_out_a, 0);
    a_retire();
    chk("rs_cnt_after", a_cnt, 1);

    // sample_cnt wrap
    force u_a.cnt_q = 16'hFFFF;
    @(negedge clk);
    release u_a.cnt_q;
    @(negedge clk);
    chk("wrap_pre", a_cnt, 16'hFFFF);
    a_send(tbl[1].ac, tbl[1].ad);
    a_wait(lat);
    a_retire();
    chk("wrap_cnt", a_cnt, 0);

    // randomized vectors with random gaps and back-pressure
    cnt_m = 0;
    for (int i = 0; i < 25; i++) begin
      ac = $urandom;
      ad = $urandom;
      e = model2(ac, ad);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a_send(ac, ad);
      a_wait(lat);
      chk("rnd_latency", lat, 8);
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      chk("rnd_hold_valid", a_out_valid, 1);
      chk("rnd_out_a", a_out_a, e);
      a_retire();
      cnt_m++;
      chk("rnd_cnt", a_cnt, cnt_m);
    end

    // instance B: streaming with out_ready high
    last_acc = -1;
    b_done = 0;
    b_in_valid = 1'b1;
    for (int i = 0; i < 41; i++) begin
      if (b_out_valid) begin
        if (b_exp_q.size() == 0) begin
          chk("b_spurious_valid", 1, 0);
        end else begin
          chk("b_out_a", b_out_a, b_exp_q.pop_front());
          chk("b_latency", i - b_acc_q.pop_front(), 3);
          b_done++;
        end
      end
      b_in_ac = 16'($urandom);
      b_in_ad = 16'($urandom);
      if (b_in_ready) begin
        b_exp_q.push_back(b_in_ac + b_in_ad);
        b_acc_q.push_back(i);
        if (last_acc >= 0) chk("b_period", i - last_acc, 4);
        last_acc = i;
      end
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    chk("b_done_count", b_done, 10);
    chk("b_cnt", b_cnt, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
